// File: rtl/sub_sat_frame_accum.sv
// Saturating frame accumulator behind the 8-bit signed subtractor: repairs overflowed
// differences, sums them with clamping, and emits one result per frame or flush.
module sub_sat_frame_accum #(
  parameter int FRAME_LEN = 16,
  parameter int ACC_W     = 16,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_diff,
  input  logic             in_ovf,
  input  logic             in_a_msb,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_diff_ovf,
  output logic             out_acc_sat
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] EMIT  = 1'b1;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             diff_ovf;
  logic             acc_sat;

  logic             accept;
  logic             close;
  logic [7:0]       sat;
  logic [ACC_W:0]   sum;
  logic             clamp_hit;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             diff_ovf_nxt;
  logic             acc_sat_nxt;

  assign in_ready = (state == ACCUM);
  assign accept   = in_valid & in_ready;

  always_comb begin
    // An overflowed subtraction's true result carries the minuend's sign.
    sat = in_ovf ? (in_a_msb ? 8'h80 : 8'h7f) : in_diff;
    sum = {acc[ACC_W-1], acc} + {{(ACC_W-7){sat[7]}}, sat};
    clamp_hit = (sum[ACC_W] != sum[ACC_W-1]);

    acc_nxt      = acc;
    count_nxt    = count;
    diff_ovf_nxt = diff_ovf;
    acc_sat_nxt  = acc_sat;
    if (accept) begin
      acc_nxt      = clamp_hit ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
      count_nxt    = count + ONE;
      diff_ovf_nxt = diff_ovf | in_ovf;
      acc_sat_nxt  = acc_sat | clamp_hit;
    end

    close = (state == ACCUM) &&
            ((accept && (count == LAST)) || (flush && (accept || (count != '0))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCUM;
      acc          <= '0;
      count        <= '0;
      diff_ovf     <= 1'b0;
      acc_sat      <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_count    <= '0;
      out_diff_ovf <= 1'b0;
      out_acc_sat  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (close) begin
            out_data     <= acc_nxt;
            out_count    <= count_nxt;
            out_diff_ovf <= diff_ovf_nxt;
            out_acc_sat  <= acc_sat_nxt;
            out_valid    <= 1'b1;
            state        <= EMIT;
            acc          <= '0;
            count        <= '0;
            diff_ovf     <= 1'b0;
            acc_sat      <= 1'b0;
          end else begin
            acc      <= acc_nxt;
            count    <= count_nxt;
            diff_ovf <= diff_ovf_nxt;
            acc_sat  <= acc_sat_nxt;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_sat_frame_accum.sv
// Directed bench: a wide (ACC_W=16) and a narrow (ACC_W=9) instance share one stimulus
// stream; the narrow one is checked where accumulator clamping matters.
module tb_sub_sat_frame_accum;

  localparam int FL = 4;
  localparam int CW = $clog2(FL + 1);

  logic clk, rst, in_valid, in_ovf, in_a_msb, flush, out_ready;
  logic [7:0] in_diff;

  logic               in_ready_w, out_valid_w, dovf_w, asat_w;
  logic signed [15:0] data_w;
  logic [CW-1:0]      count_w;

  logic               in_ready_n, out_valid_n, dovf_n, asat_n;
  logic signed [8:0]  data_n;
  logic [CW-1:0]      count_n;

  int vectors = 0;
  int errors  = 0;

  sub_sat_frame_accum #(.FRAME_LEN(FL), .ACC_W(16)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_diff(in_diff), .in_ovf(in_ovf), .in_a_msb(in_a_msb), .flush(flush),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(data_w),
    .out_count(count_w), .out_diff_ovf(dovf_w), .out_acc_sat(asat_w)
  );

  sub_sat_frame_accum #(.FRAME_LEN(FL), .ACC_W(9)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_diff(in_diff), .in_ovf(in_ovf), .in_a_msb(in_a_msb), .flush(flush),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_data(data_n),
    .out_count(count_n), .out_diff_ovf(dovf_n), .out_acc_sat(asat_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  // Present one sample (optionally with flush) for exactly one clock edge.
  task automatic send(input logic [7:0] d, input logic ovf = 1'b0,
                      input logic msb = 1'b0, input logic fl = 1'b0);
    in_valid = 1'b1; in_diff = d; in_ovf = ovf; in_a_msb = msb; flush = fl;
    @(negedge clk);
    in_valid = 1'b0; in_ovf = 1'b0; in_a_msb = 1'b0; flush = 1'b0; in_diff = 8'h00;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_diff = 8'h00; in_ovf = 1'b0; in_a_msb = 1'b0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_out_valid", out_valid_w, 0);
    check("rst_out_data", data_w, 0);
    check("rst_out_count", count_w, 0);
    check("rst_in_ready", in_ready_w, 1);

    // Basic frame: 10 - 3 + 25 + 0 = 32
    send(8'd10); send(8'hFD); send(8'd25);
    check("basic_pre_valid", out_valid_w, 0);
    send(8'd0);
    check("basic_valid", out_valid_w, 1);
    check("basic_in_ready", in_ready_w, 0);
    check("basic_data", data_w, 32);
    check("basic_count", count_w, 4);
    check("basic_dovf", dovf_w, 0);
    check("basic_asat", asat_w, 0);
    idle();
    check("basic_valid_drop", out_valid_w, 0);
    check("basic_ready_back", in_ready_w, 1);

    // Input saturation: +127 - 128 + 5 + 5 = 9
    send(8'h96, 1'b1, 1'b0); send(8'h6A, 1'b1, 1'b1); send(8'd5); send(8'd5);
    check("sat_valid", out_valid_w, 1);
    check("sat_data", data_w, 9);
    check("sat_count", count_w, 4);
    check("sat_dovf", dovf_w, 1);
    check("sat_asat", asat_w, 0);
    idle();

    // Accumulator clamp on the 9-bit instance
    repeat (4) send(8'h7F);
    check("clampp_valid", out_valid_n, 1);
    check("clampp_data_n", data_n, 255);
    check("clampp_asat_n", asat_n, 1);
    check("clampp_data_w", data_w, 508);
    check("clampp_asat_w", asat_w, 0);
    idle();
    repeat (4) send(8'h80);
    check("clampn_data_n", data_n, -256);
    check("clampn_asat_n", asat_n, 1);
    check("clampn_dovf_n", dovf_n, 0);
    check("clampn_data_w", data_w, -512);
    idle();

    // Backpressure: result held, in_valid ignored
    out_ready = 1'b0;
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid_w, 1);
      check("bp_data", data_w, 10);
      check("bp_count", count_w, 4);
      check("bp_in_ready", in_ready_w, 0);
      send(8'd50);
    end
    out_ready = 1'b1;
    idle();
    check("bp_handshake_valid", out_valid_w, 0);
    check("bp_handshake_ready", in_ready_w, 1);
    repeat (4) send(8'd1);
    check("bp_after_data", data_w, 4);
    check("bp_after_count", count_w, 4);
    idle();

    // Flush alone after two samples
    send(8'd7); send(8'd8);
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    check("flush_valid", out_valid_w, 1);
    check("flush_data", data_w, 15);
    check("flush_count", count_w, 2);
    idle();
    // Flush together with the third sample
    send(8'd7); send(8'd8); send(8'd1, 1'b0, 1'b0, 1'b1);
    check("flushacc_valid", out_valid_w, 1);
    check("flushacc_data", data_w, 16);
    check("flushacc_count", count_w, 3);
    idle();
    // Flush on an empty frame does nothing
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    check("flush_empty_valid", out_valid_w, 0);
    idle();
    check("flush_empty_valid2", out_valid_w, 0);
    repeat (4) send(8'd2);
    check("flush_empty_after_data", data_w, 8);
    check("flush_empty_after_count", count_w, 4);
    idle();

    // Reset mid-frame
    send(8'd5); send(8'd5);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    check("rst_mid_valid", out_valid_w, 0);
    repeat (4) send(8'd1);
    check("rst_mid_data", data_w, 4);
    check("rst_mid_count", count_w, 4);
    idle();

    // Reset while holding a result
    out_ready = 1'b0;
    repeat (4) send(8'd3);
    check("rst_emit_pre_valid", out_valid_w, 1);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    check("rst_emit_valid", out_valid_w, 0);
    check("rst_emit_in_ready", in_ready_w, 1);
    check("rst_emit_data", data_w, 0);
    out_ready = 1'b1;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
